// File: rtl/car_sequencer_pkg.sv
// Shared control-unit definitions: CAR encodings, register numbers and
// the source-operand classification used when decoding instructions.
package car_sequencer_pkg;

  localparam int CAR_BITS = 6;
  typedef logic [CAR_BITS-1:0] car_t;

  localparam logic [3:0] PC = 4'd0;
  localparam logic [3:0] SP = 4'd1;
  localparam logic [3:0] SR = 4'd2;
  localparam logic [3:0] R3 = 4'd3;

  // Each sequence occupies a contiguous run so that stepping is CAR+1.
  localparam car_t CAR_0        = 6'd0;
  localparam car_t CAR_REG_REG  = 6'd1;
  localparam car_t CAR_REG_IDX0 = 6'd2,  CAR_REG_IDX1 = 6'd3,  CAR_REG_IDX2 = 6'd4,  CAR_REG_IDX3 = 6'd5;
  localparam car_t CAR_IND_REG0 = 6'd6,  CAR_IND_REG1 = 6'd7;
  localparam car_t CAR_IND_IDX0 = 6'd8,  CAR_IND_IDX1 = 6'd9,  CAR_IND_IDX2 = 6'd10, CAR_IND_IDX3 = 6'd11;
  localparam car_t CAR_IND_IDX4 = 6'd12;
  localparam car_t CAR_IDX_REG0 = 6'd13, CAR_IDX_REG1 = 6'd14, CAR_IDX_REG2 = 6'd15;
  localparam car_t CAR_IDX_IDX0 = 6'd16, CAR_IDX_IDX1 = 6'd17, CAR_IDX_IDX2 = 6'd18, CAR_IDX_IDX3 = 6'd19;
  localparam car_t CAR_IDX_IDX4 = 6'd20, CAR_IDX_IDX5 = 6'd21;
  localparam car_t CAR_1OP_REG  = 6'd22;
  localparam car_t CAR_1OP_IND0 = 6'd23, CAR_1OP_IND1 = 6'd24, CAR_1OP_IND2 = 6'd25;
  localparam car_t CAR_1OP_IDX0 = 6'd26, CAR_1OP_IDX1 = 6'd27, CAR_1OP_IDX2 = 6'd28, CAR_1OP_IDX3 = 6'd29;
  localparam car_t CAR_PUSH_REG0 = 6'd30, CAR_PUSH_REG1 = 6'd31, CAR_PUSH_REG2 = 6'd32;
  localparam car_t CAR_PUSH_IND0 = 6'd33, CAR_PUSH_IND1 = 6'd34, CAR_PUSH_IND2 = 6'd35;
  localparam car_t CAR_PUSH_IDX0 = 6'd36, CAR_PUSH_IDX1 = 6'd37, CAR_PUSH_IDX2 = 6'd38, CAR_PUSH_IDX3 = 6'd39;
  localparam car_t CAR_CALL_REG0 = 6'd40, CAR_CALL_REG1 = 6'd41, CAR_CALL_REG2 = 6'd42;
  localparam car_t CAR_CALL_IND0 = 6'd43, CAR_CALL_IND1 = 6'd44, CAR_CALL_IND2 = 6'd45;
  localparam car_t CAR_CALL_IDX0 = 6'd46, CAR_CALL_IDX1 = 6'd47, CAR_CALL_IDX2 = 6'd48, CAR_CALL_IDX3 = 6'd49;
  localparam car_t CAR_RETI0 = 6'd50, CAR_RETI1 = 6'd51, CAR_RETI2 = 6'd52, CAR_RETI3 = 6'd53;
  localparam car_t CAR_JMP0  = 6'd54;
  localparam car_t CAR_INT0  = 6'd55, CAR_INT1 = 6'd56, CAR_INT2 = 6'd57, CAR_INT3 = 6'd58, CAR_INT4 = 6'd59;

  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_IDX = 2'd1,
    SRC_IND = 2'd2
  } src_class_e;

  // R3 is always a constant generator and SR with As=1x yields constants 4/8.
  function automatic src_class_e src_class(input logic [3:0] reg_num, input logic [1:0] as_mode);
    if (as_mode == 2'b00 || reg_num == R3 || (reg_num == SR && as_mode[1]))
      return SRC_REG;
    else if (as_mode == 2'b01)
      return SRC_IDX;
    else
      return SRC_IND;
  endfunction

  function automatic logic is_last(input car_t c);
    case (c)
      CAR_REG_REG, CAR_REG_IDX3, CAR_IND_REG1, CAR_IND_IDX4, CAR_IDX_REG2, CAR_IDX_IDX5,
      CAR_1OP_REG, CAR_1OP_IND2, CAR_1OP_IDX3, CAR_PUSH_REG2, CAR_PUSH_IND2, CAR_PUSH_IDX3,
      CAR_CALL_REG2, CAR_CALL_IND2, CAR_CALL_IDX3, CAR_RETI3, CAR_JMP0: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/car_sequencer_if.sv
// Bus between the sequencer (slave) and whatever feeds it instruction words.
// There is no valid/ready pair: stall is the only flow control, and while it
// is high every register behind the slave modport holds its value.
interface car_sequencer_if #(
  parameter int CAR_BITS = car_sequencer_pkg::CAR_BITS
);
  logic                stall;
  logic [15:0]         mdb_in;
  logic                int_req;
  logic                gie;
  logic [CAR_BITS-1:0] CAR;
  logic [15:0]         IR;
  logic                int_ack;
  logic                instr_done;

  modport master (output stall, mdb_in, int_req, gie,
                  input  CAR, IR, int_ack, instr_done);
  modport slave  (input  stall, mdb_in, int_req, gie,
                  output CAR, IR, int_ack, instr_done);
endinterface

// File: rtl/car_sequencer_decode.sv
// Combinational instruction decode: fetched word -> first CAR of its
// microcode sequence (CAR_0 means the word executes as a NOP).
module car_decode
  import car_sequencer_pkg::*;
(
  input  logic [15:0] mdb_in,
  output car_t        first_car
);
  src_class_e cls_i;
  src_class_e cls_ii;

  always_comb begin
    // Format I sources live in [11:8]; format II operands in [3:0].
    cls_i     = src_class(mdb_in[11:8], mdb_in[5:4]);
    cls_ii    = src_class(mdb_in[3:0], mdb_in[5:4]);
    first_car = CAR_0;
    if (mdb_in[15:12] >= 4'd4) begin
      case (cls_i)
        SRC_REG: first_car = mdb_in[7] ? CAR_REG_IDX0 : CAR_REG_REG;
        SRC_IDX: first_car = mdb_in[7] ? CAR_IDX_IDX0 : CAR_IDX_REG0;
        default: first_car = mdb_in[7] ? CAR_IND_IDX0 : CAR_IND_REG0;
      endcase
    end else if (mdb_in[15:10] == 6'b000100) begin
      case (mdb_in[9:7])
        3'b000, 3'b001, 3'b010, 3'b011:
          first_car = (cls_ii == SRC_REG) ? CAR_1OP_REG :
                      (cls_ii == SRC_IDX) ? CAR_1OP_IDX0 : CAR_1OP_IND0;
        3'b100:
          first_car = (cls_ii == SRC_REG) ? CAR_PUSH_REG0 :
                      (cls_ii == SRC_IDX) ? CAR_PUSH_IDX0 : CAR_PUSH_IND0;
        3'b101:
          first_car = (cls_ii == SRC_REG) ? CAR_CALL_REG0 :
                      (cls_ii == SRC_IDX) ? CAR_CALL_IDX0 : CAR_CALL_IND0;
        3'b110:  first_car = CAR_RETI0;
        default: first_car = CAR_0;
      endcase
    end else if (mdb_in[15:13] == 3'b001) begin
      first_car = CAR_JMP0;
    end
  end
endmodule

// File: rtl/car_sequencer.sv
// Moore microcode sequencer: CAR is the state register; IR is captured at
// fetch, interrupts are taken only between instructions.
module car_sequencer #(
  parameter int CAR_BITS = car_sequencer_pkg::CAR_BITS
) (
  input  logic           clk,
  input  logic           rst,
  car_sequencer_if.slave bus
);
  import car_sequencer_pkg::*;

  car_t        car_q;
  car_t        car_nxt;
  car_t        dec_car;
  logic [15:0] ir_q;
  logic        int_ack_q;
  logic        instr_done_q;
  logic        done_nxt;

  car_decode u_decode (
    .mdb_in    (bus.mdb_in),
    .first_car (dec_car)
  );

  // Decode from mdb_in directly: IR is only being loaded on this same edge.
  always_comb begin
    car_nxt  = CAR_0;
    done_nxt = 1'b0;
    if (car_q == CAR_0) begin
      car_nxt  = dec_car;
      done_nxt = (dec_car == CAR_0);
    end else if (is_last(car_q)) begin
      car_nxt  = (bus.int_req && bus.gie) ? CAR_INT0 : CAR_0;
      done_nxt = 1'b1;
    end else if (car_q < CAR_INT4) begin
      car_nxt = car_q + car_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      car_q        <= CAR_0;
      ir_q         <= 16'h0000;
      int_ack_q    <= 1'b0;
      instr_done_q <= 1'b0;
    end else if (!bus.stall) begin
      car_q        <= car_nxt;
      int_ack_q    <= (car_nxt == CAR_INT0);
      instr_done_q <= done_nxt;
      if (car_q == CAR_0) ir_q <= bus.mdb_in;
    end
  end

  assign bus.CAR        = CAR_BITS'(car_q);
  assign bus.IR         = ir_q;
  assign bus.int_ack    = int_ack_q;
  assign bus.instr_done = instr_done_q;
endmodule

// File: tb/tb_car_sequencer.sv
// Bench for car_sequencer: directed instruction scenarios plus random
// traffic, compared cycle by cycle against a sequence-level model.
module tb_car_sequencer;
  import car_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  car_sequencer_if bus ();

  car_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model: current CAR, remaining states of the running sequence, outputs.
  logic [5:0]  exp_q[$];
  logic [5:0]  m_car;
  logic [15:0] m_ir;
  logic        m_ack;
  logic        m_done;
  bit          m_in_int;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [1:0] ref_class(input logic [3:0] r, input logic [1:0] as_m);
    if (as_m == 2'b00 || r == 4'd3 || (r == 4'd2 && as_m >= 2'b10)) return 2'd0;  // reg
    if (as_m == 2'b01) return 2'd1;                                              // indexed
    return 2'd2;                                                                 // indirect
  endfunction

  // Sequence-level decode: first CAR and length (0 = NOP).
  task automatic ref_decode(input logic [15:0] w, output logic [5:0] first, output int len);
    logic [1:0] cls;
    first = CAR_0;
    len   = 0;
    if (w[15:12] >= 4'd4) begin
      cls = ref_class(w[11:8], w[5:4]);
      if (cls == 2'd0)      begin first = w[7] ? CAR_REG_IDX0 : CAR_REG_REG;  len = w[7] ? 4 : 1; end
      else if (cls == 2'd1) begin first = w[7] ? CAR_IDX_IDX0 : CAR_IDX_REG0; len = w[7] ? 6 : 3; end
      else                  begin first = w[7] ? CAR_IND_IDX0 : CAR_IND_REG0; len = w[7] ? 5 : 2; end
    end else if (w[15:10] == 6'b000100) begin
      cls = ref_class(w[3:0], w[5:4]);
      if (w[9:7] < 3'd4) begin
        first = (cls == 2'd0) ? CAR_1OP_REG : (cls == 2'd1) ? CAR_1OP_IDX0 : CAR_1OP_IND0;
        len   = (cls == 2'd0) ? 1 : (cls == 2'd1) ? 4 : 3;
      end else if (w[9:7] == 3'd4) begin
        first = (cls == 2'd0) ? CAR_PUSH_REG0 : (cls == 2'd1) ? CAR_PUSH_IDX0 : CAR_PUSH_IND0;
        len   = (cls == 2'd1) ? 4 : 3;
      end else if (w[9:7] == 3'd5) begin
        first = (cls == 2'd0) ? CAR_CALL_REG0 : (cls == 2'd1) ? CAR_CALL_IDX0 : CAR_CALL_IND0;
        len   = (cls == 2'd1) ? 4 : 3;
      end else if (w[9:7] == 3'd6) begin
        first = CAR_RETI0;
        len   = 4;
      end
    end else if (w[15:13] == 3'b001) begin
      first = CAR_JMP0;
      len   = 1;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_car    = CAR_0;
    m_ir     = 16'h0000;
    m_ack    = 1'b0;
    m_done   = 1'b0;
    m_in_int = 1'b0;
  endtask

  task automatic model_step();
    logic [5:0] first;
    int         len;
    if (bus.stall) return;
    m_ack  = 1'b0;
    m_done = 1'b0;
    if (m_car == CAR_0) begin
      m_ir = bus.mdb_in;
      ref_decode(bus.mdb_in, first, len);
      if (len == 0) m_done = 1'b1;
      for (int i = 0; i < len; i++) exp_q.push_back(first + 6'(i));
    end else if (exp_q.size() == 0) begin
      if (m_in_int) m_in_int = 1'b0;
      else begin
        m_done = 1'b1;
        if (bus.int_req && bus.gie) begin
          for (int i = 0; i < 5; i++) exp_q.push_back(CAR_INT0 + 6'(i));
          m_in_int = 1'b1;
          m_ack    = 1'b1;
        end
      end
    end
    m_car = (exp_q.size() != 0) ? exp_q.pop_front() : CAR_0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_car"},  16'(bus.CAR),        16'(m_car));
    check({tag, "_ir"},   bus.IR,              m_ir);
    check({tag, "_ack"},  16'(bus.int_ack),    16'(m_ack));
    check({tag, "_done"}, 16'(bus.instr_done), 16'(m_done));
  endtask

  task automatic step(input bit s, input bit irq, input bit g, input logic [15:0] w);
    @(negedge clk);
    bus.stall   = s;
    bus.int_req = irq;
    bus.gie     = g;
    bus.mdb_in  = w;
    model_step();
    @(posedge clk);
    #1;
    check_all("cyc");
  endtask

  task automatic fetch_ready();
    int n = 0;
    while (m_car != CAR_0 && n < 20) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      n++;
    end
    check("at_fetch", 16'(bus.CAR), 16'(CAR_0));
  endtask

  function automatic logic [15:0] gen_word();
    case ($urandom_range(0, 5))
      0:       return {4'($urandom_range(4, 15)), 12'($urandom)};
      1:       return {4'($urandom_range(4, 15)), 2'b00, 2'($urandom), 8'($urandom)};
      2:       return {6'b000100, 6'($urandom), 4'($urandom_range(0, 3))};
      3:       return {6'b000100, 10'($urandom)};
      4:       return {3'b001, 13'($urandom)};
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    bus.stall   = 1'b0;
    bus.int_req = 1'b0;
    bus.gie     = 1'b0;
    bus.mdb_in  = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;

    // Simple register move, then instr_done on return to fetch.
    step(1'b0, 1'b0, 1'b0, 16'h4A0B);
    check("r30_car", 16'(bus.CAR), 16'(CAR_REG_REG));
    check("r30_ir", bus.IR, 16'h4A0B);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("r30_done", 16'(bus.instr_done), 16'd1);

    // Longest format I sequence, then constant-generator source.
    fetch_ready();
    step(1'b0, 1'b0, 1'b0, 16'h4A9B);
    for (int i = 1; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0000);
      check("r31_idx", 16'(bus.CAR), 16'(CAR_IDX_IDX0 + 6'(i)));
    end
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("r31_end", 16'(bus.CAR), 16'(CAR_0));
    step(1'b0, 1'b0, 1'b0, 16'h4322);
    check("r31_cg", 16'(bus.CAR), 16'(CAR_REG_REG));

    fetch_ready();
    step(1'b0, 1'b0, 1'b0, 16'h1285);
    check("r32_call", 16'(bus.CAR), 16'(CAR_CALL_REG0));
    fetch_ready();
    step(1'b0, 1'b0, 1'b0, 16'h1300);
    check("r32_reti", 16'(bus.CAR), 16'(CAR_RETI0));
    fetch_ready();
    step(1'b0, 1'b0, 1'b0, 16'h3C05);
    check("r32_jmp", 16'(bus.CAR), 16'(CAR_JMP0));
    fetch_ready();
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("r32_nop", 16'(bus.CAR), 16'(CAR_0));
    check("r32_nop_done", 16'(bus.instr_done), 16'd1);

    // Interrupt raised mid-sequence is taken only at its end.
    fetch_ready();
    step(1'b0, 1'b0, 1'b0, 16'h4A9B);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 16'h0000);
    check("r33_still_seq", 16'(bus.CAR), 16'(CAR_IDX_IDX5));
    step(1'b0, 1'b1, 1'b1, 16'h0000);
    check("r33_int0", 16'(bus.CAR), 16'(CAR_INT0));
    check("r33_ack", 16'(bus.int_ack), 16'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 16'h0000);
    check("r33_back", 16'(bus.CAR), 16'(CAR_0));
    check("r33_ir_kept", bus.IR, 16'h4A9B);
    step(1'b0, 1'b1, 1'b0, 16'h4A9B);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
    check("r33_gie0", 16'(bus.CAR), 16'(CAR_0));

    // Stall freezes CAR and IR.
    fetch_ready();
    step(1'b0, 1'b0, 1'b0, 16'h4A8B);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 16'h1234);
      check("r34_hold", 16'(bus.CAR), 16'(CAR_REG_IDX1));
      check("r34_ir", bus.IR, 16'h4A8B);
    end
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("r34_resume", 16'(bus.CAR), 16'(CAR_REG_IDX2));

    // Asynchronous reset mid-sequence.
    fetch_ready();
    step(1'b0, 1'b0, 1'b0, 16'h4AAB);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("r35_pre", 16'(bus.CAR), 16'(CAR_IND_IDX2));
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_all("r35_async");
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 16'h4A0B);
    check("r35_fetch", 16'(bus.CAR), 16'(CAR_REG_REG));
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    check("r35_done", 16'(bus.instr_done), 16'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
           1'($urandom), gen_word());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
